counter_driver: RTL and testbench

//  Command-side controller for the 4-bit BCD up/down counter (0..9, wrap 9->0 up, 0->9 down).
//  - Accepts a target digit through a valid/ready request.
//  - Either presets the counter via load, or steps it one digit at a time to the target,

---
 rtl/counter_driver.sv | 146 ++++++++++++++
 tb/tb_counter_driver.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_driver.sv
// Command-side controller for a BCD up/down counter: load or step to a target.
// Define WRAP_PATH_EN to step along the shortest path on the 10-digit ring.
module counter_driver #(
  parameter int STEP_CYCLES = 4,
  parameter int MAX_DIGIT   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_target,
  input  logic       req_load,
  input  logic [3:0] count,
  output logic       cnt_en,
  output logic       cnt_up_down,
  output logic       cnt_load,
  output logic [3:0] cnt_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE,
    WAIT,
    DONE
  } state_t;

  localparam int DW =
    (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES - 1) : 1;
  localparam int SW = $clog2(MAX_DIGIT + 2);

  localparam logic [DW-1:0] DWELL = DW'(STEP_CYCLES - 2);
  localparam logic [SW-1:0] STEP_LIM = SW'(MAX_DIGIT + 1);
  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  state_t        state;
  logic [3:0]    target;
  logic          dir;
  logic [DW-1:0] dwell;
  logic [SW-1:0] steps;
  logic          dir_up;

`ifdef WRAP_PATH_EN
  localparam logic [4:0] RING = 5'(MAX_DIGIT + 1);
  localparam logic [4:0] HALF = 5'((MAX_DIGIT + 1) / 2);
  logic [4:0] up_dist;

  // Distance going up around the ring; ties go up.
  always_comb begin
    up_dist = '0;
    if (req_target >= count)
      up_dist = {1'b0, req_target} - {1'b0, count};
    else
      up_dist = {1'b0, req_target} + RING - {1'b0, count};
    dir_up = (up_dist <= HALF);
  end
`else
  always_comb begin
    dir_up = (req_target > count);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      target      <= '0;
      dir         <= 1'b0;
      dwell       <= '0;
      steps       <= '0;
      req_ready   <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_up_down <= 1'b0;
      cnt_load    <= 1'b0;
      cnt_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      cnt_en   <= 1'b0;
      cnt_load <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (req_valid && req_ready) begin
            if (req_target > MAX_D) begin
              err <= 1'b1;
            end else begin
              target    <= req_target;
              dir       <= dir_up;
              steps     <= '0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              if (req_load)
                state <= LOAD;
              else if (req_target == count)
                state <= DONE;
              else
                state <= MOVE;
            end
          end
        end
        LOAD: begin
          cnt_load <= 1'b1;
          cnt_data <= target;
          state    <= DONE;
        end
        MOVE: begin
          cnt_en      <= 1'b1;
          cnt_up_down <= dir;
          steps       <= steps + 1'b1;
          dwell       <= DWELL;
          state       <= WAIT;
        end
        WAIT: begin
          if (dwell != '0) begin
            dwell <= dwell - 1'b1;
          end else if (count == target) begin
            state <= DONE;
          end else if (steps == STEP_LIM) begin
            // Feedback never matched: give up without done.
            err       <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= MOVE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver with a behavioural BCD counter model.
// Expectations follow WRAP_PATH_EN when it is defined.
module tb_counter_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_target;
  logic       req_load;
  logic [3:0] count;
  logic       cnt_en;
  logic       cnt_up_down;
  logic       cnt_load;
  logic [3:0] cnt_data;
  logic       busy;
  logic       done;
  logic       err;

  logic       preset;
  logic [3:0] preset_val;
  logic       freeze;

  int errors = 0;
  int checks = 0;

  int       en_q[$];
  bit       up_q[$];
  int       ld_q[$];
  logic [3:0] ld_data;
  int       done_at;
  int       err_at;
  int       ovl;

`ifdef WRAP_PATH_EN
  localparam int T3_STEPS = 3;
  localparam bit T3_UP = 1'b1;
`else
  localparam int T3_STEPS = 7;
  localparam bit T3_UP = 1'b0;
`endif

  counter_driver #(.STEP_CYCLES(4), .MAX_DIGIT(9)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_target(req_target),
    .req_load(req_load),
    .count(count),
    .cnt_en(cnt_en),
    .cnt_up_down(cnt_up_down),
    .cnt_load(cnt_load),
    .cnt_data(cnt_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // BCD counter model; ignores rst_n like the real counter.
  always @(posedge clk) begin
    if (preset)
      count <= preset_val;
    else if (cnt_load)
      count <= cnt_data;
    else if (cnt_en && !freeze) begin
      if (cnt_up_down)
        count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
      else
        count <= (count == 4'd0) ? 4'd9 : count - 4'd1;
    end
  end

  task automatic set_count(input logic [3:0] v);
    @(negedge clk);
    preset = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset = 1'b0;
  endtask

  // Handshake; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] t, input logic l);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_wait: req_ready=%b want 1", req_ready);
    end
    req_target = t;
    req_load = l;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Records pulses for k = 0..limit cycles after acceptance.
  task automatic observe(input int limit);
    en_q.delete();
    up_q.delete();
    ld_q.delete();
    done_at = -1;
    err_at = -1;
    ovl = 0;
    ld_data = 4'hx;
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) @(negedge clk);
      if (cnt_en) begin
        en_q.push_back(k);
        up_q.push_back(cnt_up_down);
      end
      if (cnt_load) begin
        ld_q.push_back(k);
        ld_data = cnt_data;
      end
      if (cnt_en && cnt_load) ovl++;
      if (done) begin
        done_at = k;
        break;
      end
      if (err) begin
        err_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_target = 4'd0;
    req_load = 1'b0;
    freeze = 1'b0;
    preset = 1'b1;
    preset_val = 4'd3;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, cnt_en, cnt_up_down, cnt_load, cnt_data,
         busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {req_ready, cnt_en, cnt_up_down, cnt_load,
                cnt_data, busy, done, err});
    end
    rst_n = 1'b1;
    preset = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 1", req_ready);
    end
  endtask

  task automatic test_step_up();
    int bad = 0;
    int ups = 0;
    issue(4'd7, 1'b0);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy: busy=%b ready=%b want 1 0",
               busy, req_ready);
    end
    observe(40);
    checks++;
    if (done_at != 17) begin
      errors++;
      $display("FAIL t1_done_cycle: got %0d want 17", done_at);
    end
    checks++;
    if (en_q.size() != 4) begin
      errors++;
      $display("FAIL t1_steps: got %0d want 4", en_q.size());
    end
    foreach (en_q[i]) begin
      if (en_q[i] != 1 + 4 * i) bad++;
      if (up_q[i]) ups++;
    end
    checks++;
    if (bad != 0 || ups != en_q.size()) begin
      errors++;
      $display("FAIL t1_spacing_dir: bad=%0d ups=%0d want 0 %0d",
               bad, ups, en_q.size());
    end
    checks++;
    if (count !== 4'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_final: count=%0d busy=%b want 7 0",
               count, busy);
    end
  endtask

  task automatic test_load();
    set_count(4'd2);
    issue(4'd5, 1'b1);
    observe(10);
    checks++;
    if (ld_q.size() != 1 || ld_q[0] != 1 || ld_data !== 4'd5) begin
      errors++;
      $display("FAIL t2_load: n=%0d data=%0d want 1 at cycle 1 data 5",
               ld_q.size(), ld_data);
    end
    checks++;
    if (done_at != 2 || en_q.size() != 0) begin
      errors++;
      $display("FAIL t2_done: done_at=%0d en=%0d want 2 0",
               done_at, en_q.size());
    end
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL t2_count: got %0d want 5", count);
    end
  endtask

  task automatic test_wrap_path();
    int dirs_ok = 0;
    set_count(4'd8);
    issue(4'd1, 1'b0);
    observe(60);
    foreach (up_q[i]) if (up_q[i] == T3_UP) dirs_ok++;
    checks++;
    if (en_q.size() != T3_STEPS || dirs_ok != T3_STEPS) begin
      errors++;
      $display("FAIL t3_path: steps=%0d dir_ok=%0d want %0d",
               en_q.size(), dirs_ok, T3_STEPS);
    end
    checks++;
    if (done_at != T3_STEPS * 4 + 1 || count !== 4'd1) begin
      errors++;
      $display("FAIL t3_done: done_at=%0d count=%0d want %0d 1",
               done_at, count, T3_STEPS * 4 + 1);
    end
  endtask

  task automatic test_reject();
    issue(4'd12, 1'b0);
    checks++;
    if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_err: err=%b ready=%b busy=%b want 1 1 0",
               err, req_ready, busy);
    end
    observe(5);
    checks++;
    if (en_q.size() != 0 || ld_q.size() != 0 || count !== 4'd1) begin
      errors++;
      $display("FAIL t4_untouched: en=%0d ld=%0d count=%0d want 0 0 1",
               en_q.size(), ld_q.size(), count);
    end
    issue(4'd1, 1'b0);
    observe(10);
    checks++;
    if (done_at != 1 || en_q.size() != 0) begin
      errors++;
      $display("FAIL t4_equal: done_at=%0d en=%0d want 1 0",
               done_at, en_q.size());
    end
  endtask

  task automatic test_abort();
    set_count(4'd0);
    issue(4'd4, 1'b0);
    observe(6);
    checks++;
    if (en_q.size() != 2 || busy !== 1'b1 || count !== 4'd2) begin
      errors++;
      $display("FAIL t5_pre: en=%0d busy=%b count=%0d want 2 1 2",
               en_q.size(), busy, count);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, cnt_en, cnt_up_down, cnt_load, cnt_data,
         busy, done, err} !== 11'd0 || count !== 4'd2) begin
      errors++;
      $display("FAIL t5_abort: outs=%b count=%0d want 0 2",
               {req_ready, cnt_en, cnt_up_down, cnt_load,
                cnt_data, busy, done, err}, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL t5_release: ready=%b done=%b want 1 0",
               req_ready, done);
    end
  endtask

  task automatic test_no_converge();
    set_count(4'd0);
    freeze = 1'b1;
    issue(4'd6, 1'b0);
    observe(60);
    checks++;
    if (err_at != 40 || done_at != -1 || en_q.size() != 10) begin
      errors++;
      $display("FAIL t6_err: err_at=%0d done_at=%0d en=%0d want 40 -1 10",
               err_at, done_at, en_q.size());
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL t6_idle: ready=%b busy=%b count=%0d want 1 0 0",
               req_ready, busy, count);
    end
    freeze = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int loads = 0;
    set_count(4'd0);
    issue(4'd3, 1'b1);
    req_target = 4'd9;
    req_load = 1'b1;
    req_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (cnt_load) loads++;
      if (k == 2) begin
        req_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL busy_done: done=%b want 1", done);
        end
      end
    end
    checks++;
    if (loads != 1 || count !== 4'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: loads=%0d count=%0d busy=%b want 1 3 0",
               loads, count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_load();
    test_wrap_path();
    test_reject();
    test_abort();
    test_no_converge();
    test_busy_ignore();
    checks++;
    if (ovl != 0) begin
      errors++;
      $display("FAIL en_load_overlap: got %0d want 0", ovl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
